lsu_unit: RTL

Load/store unit directly downstream of the ALU in the NPC execute path. It takes the ALU result as the effective address, plus rs2 store data and the instruction's funct3. It performs one aligned memory access over a valid/ready memory port and returns a sign- or zero-extended load result, or a store completion, to writeback. It also detects misaligned and illegal accesses without touching memory.

---
 rtl/lsu_unit_pkg.sv | 20 ++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_unit_pkg.sv
// Shared LSU definitions: RV32I load/store funct3 codes and FSM state encoding.
package lsu_unit_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for one 32-bit access: store masks/replication, load extraction/extension, legality.
// Purely combinational, no backpressure.
module lsu_align
    import lsu_unit_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        bad_o
);

    logic [31:0] shifted;
    logic        legal;
    logic        misaligned;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = wdata_i;
        case (funct3_i)
            LSU_SB: begin
                wmask_o = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            LSU_SH: begin
                wmask_o = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            LSU_SW:  wmask_o = 4'b1111;
            default: wmask_o = 4'b0000;
        endcase
    end

    always_comb begin
        rdata_o = shifted;
        case (funct3_i)
            LSU_LB:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            LSU_LH:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            LSU_LBU: rdata_o = {24'd0, shifted[7:0]};
            LSU_LHU: rdata_o = {16'd0, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

    // Size comes from funct3[1:0]; only stores reject the unsigned variants.
    always_comb begin
        case (funct3_i)
            LSU_LB, LSU_LH, LSU_LW: legal = 1'b1;
            LSU_LBU, LSU_LHU:       legal = ~we_i;
            default:                legal = 1'b0;
        endcase
        misaligned = ((funct3_i[1:0] == 2'b01) && off_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (off_i != 2'b00));
        bad_o = ~legal | misaligned;
    end

endmodule

// File: rtl/lsu_unit.sv
// Single-outstanding load/store unit: ALU address in, one aligned memory access, extended result out.
// 3 cycles with zero-wait memory, 1 cycle for rejected ops; stalls on mem_ready/mem_rvalid/rsp_ready.
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    input  logic              req_we,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rerr
);

    lsu_state_e        state_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic              mem_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wen_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wmask_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              idle;
    logic              a_we;
    logic [2:0]        a_funct3;
    logic [1:0]        a_off;
    logic [3:0]        a_wmask;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_bad;

    assign idle      = (state_q == ST_IDLE);
    assign req_ready = idle & ~rst;

    // One aligner serves both phases: live request in IDLE, latched op afterwards.
    assign a_we     = idle ? req_we          : we_q;
    assign a_funct3 = idle ? req_funct3      : funct3_q;
    assign a_off    = idle ? req_addr[1:0]   : off_q;

    lsu_align u_align (
        .we_i     (a_we),
        .funct3_i (a_funct3),
        .off_i    (a_off),
        .wdata_i  (req_wdata),
        .rdata_i  (mem_rdata),
        .wmask_o  (a_wmask),
        .wdata_o  (a_wdata),
        .rdata_o  (a_rdata),
        .bad_o    (a_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            funct3_q    <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[1:0];
                        we_q     <= req_we;
                        if (a_bad) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= ST_RESP;
                        end else begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wen_q   <= req_we;
                            mem_wdata_q <= a_wdata;
                            mem_wmask_q <= req_we ? a_wmask : 4'b0000;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= mem_rerr;
                        rsp_rdata_q <= (mem_rerr || we_q) ? '0 : a_rdata;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
